// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - digit-serial adder with valid/ready operand and result handshakes
//
// Adds a + b + cin, DIGIT bits per clock, LSB digit first, through one registered
// carry. Optional feature macro: SERIAL_ADDER_SUB_EN adds the sub port (a - b).
//
// Parameters:
//   WIDTH      operand/sum width in bits (>= 1)
//   DIGIT      bits added per cycle; WIDTH must be a multiple of DIGIT
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operands valid
//   in_ready   block can accept operands (IDLE and not in reset)
//   a, b       operands
//   cin        carry-in (ignored when subtracting)
//   sub        subtract select (only with SERIAL_ADDER_SUB_EN)
//   out_valid  result valid (DONE)
//   out_ready  consumer accepts result
//   sum        result
//   cout       carry out of bit WIDTH-1 (1 = no borrow when subtracting)
//   ovf        signed two's-complement overflow
//   busy       high while digits are being added

module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  generate
    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("serial_adder: WIDTH must be >= 1 and a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;     // operand A, consumed from the bottom one digit per cycle
  logic [WIDTH-1:0] b_sh;     // operand B (already inverted when subtracting)
  logic             carry;
  logic [CW-1:0]    cnt;

  logic [DIGIT:0]   dsum;
  logic             carry_into_msb;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

`ifdef SERIAL_ADDER_SUB_EN
  // a - b is a + ~b + 1; the caller's cin is ignored in that mode.
  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub ? 1'b1 : cin;
`else
  assign b_eff   = b;
  assign cin_eff = cin;
`endif

  assign in_ready = (state == IDLE) && !rst;

  always_comb begin
    dsum = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
    // Carry into the top bit of this digit recovered from that bit's sum:
    // s = a ^ b ^ c  =>  c = a ^ b ^ s. On the last digit this is the carry into bit WIDTH-1.
    carry_into_msb = a_sh[DIGIT-1] ^ b_sh[DIGIT-1] ^ dsum[DIGIT-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_sh      <= '0;
      b_sh      <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_sh  <= a;
            b_sh  <= b_eff;
            carry <= cin_eff;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> DIGIT;
          b_sh  <= b_sh >> DIGIT;
          carry <= dsum[DIGIT];
          // New digit enters at the top; after N digits it has moved to [k*DIGIT +: DIGIT].
          sum   <= WIDTH'({dsum[DIGIT-1:0], sum} >> DIGIT);
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            cout      <= dsum[DIGIT];
            ovf       <= carry_into_msb ^ dsum[DIGIT];
            busy      <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
